ps2_key_tracker: RTL and testbench

Receives raw PS/2 keyboard frames, decodes set-2 scan codes, including the E0 extended and F0 release prefixes, and reports every decoded make/break event. It also drives `keyN`, a held-key level for one configured key. `keyN` feeds the keyboard edge-detect stage directly, so that stage sees an active-low "key held" signal.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_clk_filter.sv | 49 ++++
 rtl/ps2_key_tracker.sv | 170 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame FSM encoding, scan-code prefix bytes and the frame parity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_REL       = 8'hF0;
    localparam int         PS2_DATA_BITS = 8;

    // The eight data bits plus the parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the raw PS/2 clock and debounces it.
// Emits a one-cycle fall strobe on each filtered high-to-low transition.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic kbd_clk_i,
    output logic fall_o
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= kbd_clk_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            // The toggle lands on the FILTER_LEN-th consecutive cycle of disagreement.
            if (sync_q != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_q <= sync_q;
                    cnt_q  <= '0;
                    fall_q <= ~sync_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 receiver: frames bytes, resolves E0/F0 prefixes into make/break events,
// and holds an active-low level for one tracked key.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (data low on fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, releasing the byte
module ps2_key_tracker #(
    parameter logic [8:0] KEY_CODE   = 9'h175,
    parameter int         FILTER_LEN = 8,
    parameter int         TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kbdClk,
    input  logic       kbdData,
    output logic [8:0] keyCode,
    output logic       make,
    output logic       brk,
    output logic       frameErr,
    output logic       keyN
);

    import ps2_pkg::*;

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [2:0]    LAST_BIT  = 3'(PS2_DATA_BITS - 1);

    logic          fall;
    logic          data_meta_q;
    logic          data_sync_q;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          byte_valid_q;
    logic [7:0]    byte_q;
    logic          frame_err_q;

    logic          ext_q;
    logic          rel_q;
    logic [8:0]    key_code_q;
    logic          make_q;
    logic          brk_q;
    logic          key_n_q;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk_i    (clk),
        .reset_i  (reset),
        .kbd_clk_i(kbdClk),
        .fall_o   (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= kbdData;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                case (state_q)
                    ST_IDLE: begin
                        if (!data_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= data_sync_q;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_sync_q && odd_parity_ok(shift_q, parity_q)) begin
                            byte_valid_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                // A stalled keyboard must not leave the receiver stuck mid-frame.
                if (tmo_q == TMO_LIMIT) begin
                    state_q     <= ST_IDLE;
                    frame_err_q <= 1'b1;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            key_code_q <= '0;
            make_q     <= 1'b0;
            brk_q      <= 1'b0;
            key_n_q    <= 1'b1;
        end else begin
            make_q <= 1'b0;
            brk_q  <= 1'b0;
            if (frame_err_q) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (byte_valid_q) begin
                if (byte_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (byte_q == PS2_REL) begin
                    rel_q <= 1'b1;
                end else begin
                    key_code_q <= {ext_q, byte_q};
                    make_q     <= ~rel_q;
                    brk_q      <= rel_q;
                    ext_q      <= 1'b0;
                    rel_q      <= 1'b0;
                    if ({ext_q, byte_q} == KEY_CODE) begin
                        key_n_q <= rel_q;
                    end
                end
            end
        end
    end

    assign keyCode  = key_code_q;
    assign make     = make_q;
    assign brk      = brk_q;
    assign frameErr = frame_err_q;
    assign keyN     = key_n_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: table of PS/2 frames plus hand-written corner sequences,
// with decoded events checked against a queue of expected events.
module tb_ps2_key_tracker;

    localparam int         HALF   = 16;
    localparam logic [1:0] K_MAKE = 2'd0;
    localparam logic [1:0] K_BRK  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam int         NVEC   = 19;

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         has_evt;
        logic [1:0] kind;
        logic [8:0] code;
        logic       keyn;
    } vec_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [8:0] code;
        logic       keyn;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       kbdClk;
    logic       kbdData;
    logic [8:0] keyCode;
    logic       make;
    logic       brk;
    logic       frameErr;
    logic       keyN;

    int   compared   = 0;
    int   mismatched = 0;
    evt_t exp_q[$];
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    ps2_key_tracker #(
        .KEY_CODE  (9'h175),
        .FILTER_LEN(8),
        .TIMEOUT   (50000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .kbdClk  (kbdClk),
        .kbdData (kbdData),
        .keyCode (keyCode),
        .make    (make),
        .brk     (brk),
        .frameErr(frameErr),
        .keyN    (keyN)
    );

    task automatic cmp(input string name, input logic [8:0] got, input logic [8:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_evt(input logic [1:0] kind, input logic [8:0] code, input logic keyn);
        evt_t e;
        e.kind = kind;
        e.code = code;
        e.keyn = keyn;
        exp_q.push_back(e);
    endtask

    task automatic check_event();
        evt_t       e;
        logic [1:0] kind;
        int         n;
        n = int'(make) + int'(brk) + int'(frameErr);
        compared++;
        if (n > 1) begin
            mismatched++;
            $display("FAIL pulse_exclusive: got %0d pulses want 1", n);
        end
        kind = make ? K_MAKE : (brk ? K_BRK : K_ERR);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got kind %0d code %h want none", kind, keyCode);
        end else begin
            e = exp_q.pop_front();
            cmp("event_kind", {7'd0, kind}, {7'd0, e.kind});
            cmp("keyCode", keyCode, e.code);
            cmp("keyN", {8'd0, keyN}, {8'd0, e.keyn});
        end
    endtask

    // Every cycle of the run passes through here, so no output pulse goes unchecked.
    task automatic tick();
        @(negedge clk);
        if (!reset && (make || brk || frameErr)) check_event();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] frame;
        logic        par;
        par   = ~^data ^ bad_par;
        frame = {~bad_stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kbdData = frame[i];
            ticks(HALF);
            kbdClk = 1'b0;
            ticks(HALF);
            kbdClk = 1'b1;
        end
        kbdData = 1'b1;
        ticks(2 * HALF);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_event: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_keyCode"}, keyCode, 9'h000);
        cmp({tag, "_make"}, {8'd0, make}, 9'd0);
        cmp({tag, "_brk"}, {8'd0, brk}, 9'd0);
        cmp({tag, "_frameErr"}, {8'd0, frameErr}, 9'd0);
        cmp({tag, "_keyN"}, {8'd0, keyN}, 9'd1);
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 0, 0, 1, K_MAKE, 9'h01C, 1'b1};
        vecs[1]  = '{8'hE0, 0, 0, 0, K_MAKE, 9'h000, 1'b1};
        vecs[2]  = '{8'h75, 0, 0, 1, K_MAKE, 9'h175, 1'b0};
        vecs[3]  = '{8'hE0, 0, 0, 0, K_MAKE, 9'h000, 1'b0};
        vecs[4]  = '{8'h75, 0, 0, 1, K_MAKE, 9'h175, 1'b0};
        vecs[5]  = '{8'h1C, 0, 0, 1, K_MAKE, 9'h01C, 1'b0};
        vecs[6]  = '{8'hF0, 0, 0, 0, K_MAKE, 9'h000, 1'b0};
        vecs[7]  = '{8'h1C, 0, 0, 1, K_BRK,  9'h01C, 1'b0};
        vecs[8]  = '{8'h75, 0, 0, 1, K_MAKE, 9'h075, 1'b0};
        vecs[9]  = '{8'hE0, 0, 0, 0, K_MAKE, 9'h000, 1'b0};
        vecs[10] = '{8'hF0, 0, 0, 0, K_MAKE, 9'h000, 1'b0};
        vecs[11] = '{8'h75, 0, 0, 1, K_BRK,  9'h175, 1'b1};
        vecs[12] = '{8'h1C, 1, 0, 1, K_ERR,  9'h175, 1'b1};
        vecs[13] = '{8'hF0, 0, 0, 0, K_MAKE, 9'h000, 1'b1};
        vecs[14] = '{8'h1C, 0, 0, 1, K_BRK,  9'h01C, 1'b1};
        vecs[15] = '{8'hE0, 0, 0, 0, K_MAKE, 9'h000, 1'b1};
        vecs[16] = '{8'h1C, 1, 0, 1, K_ERR,  9'h01C, 1'b1};
        vecs[17] = '{8'h1C, 0, 0, 1, K_MAKE, 9'h01C, 1'b1};
        vecs[18] = '{8'h2A, 0, 1, 1, K_ERR,  9'h01C, 1'b1};

        reset   = 1'b1;
        kbdClk  = 1'b1;
        kbdData = 1'b1;
        ticks(5);
        reset = 1'b0;
        tick();
        check_reset_values("reset");

        for (int v = 0; v < NVEC; v++) begin
            if (vecs[v].has_evt) push_evt(vecs[v].kind, vecs[v].code, vecs[v].keyn);
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 11);
            drain(200);
        end

        // Clock falls while data is high: not a start bit.
        push_evt(K_ERR, 9'h01C, 1'b1);
        kbdData = 1'b1;
        ticks(HALF);
        kbdClk = 1'b0;
        ticks(HALF);
        kbdClk = 1'b1;
        ticks(2 * HALF);
        drain(200);

        // Short low glitch must be filtered out; the next frame decodes normally.
        kbdClk = 1'b0;
        ticks(3);
        kbdClk = 1'b1;
        ticks(40);
        push_evt(K_MAKE, 9'h02A, 1'b1);
        send_frame(8'h2A, 0, 0, 11);
        drain(200);

        // Start bit plus four data bits, then the keyboard goes silent.
        push_evt(K_ERR, 9'h02A, 1'b1);
        send_frame(8'h1C, 0, 0, 5);
        ticks(45000);
        compared++;
        if (exp_q.size() != 1) begin
            mismatched++;
            $display("FAIL timeout_early: got %0d pending want 1", exp_q.size());
        end
        drain(10000);
        push_evt(K_MAKE, 9'h01C, 1'b1);
        send_frame(8'h1C, 0, 0, 11);
        drain(200);

        // Hold the tracked key, then reset in the middle of a repeat.
        push_evt(K_MAKE, 9'h175, 1'b0);
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);
        drain(200);
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 4);
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        tick();
        check_reset_values("midreset");
        push_evt(K_MAKE, 9'h01C, 1'b1);
        send_frame(8'h1C, 0, 0, 11);
        drain(200);

        ticks(50);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_events: got %0d want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
